// File: rtl/sensor_pulse_gen.sv
// rtl/sensor_pulse_gen.sv - programmable square-wave pulse-train generator
module sensor_pulse_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] high_len,
    input  logic [WIDTH-1:0] n_pulses,
    output logic             sensor,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [WIDTH-1:0] pulse_count
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic             sensor_q, sensor_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic [WIDTH-1:0] pulse_count_q, pulse_count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] npulses_q, npulses_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] periods_q, periods_d;
    logic [WIDTH-1:0] low_len;
    logic [WIDTH-1:0] periods_inc;

    assign low_len     = period_q - high_q;
    assign periods_inc = periods_q + WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        sensor_d      = sensor_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
        pulse_count_d = pulse_count_q;
        period_d      = period_q;
        high_d        = high_q;
        npulses_d     = npulses_q;
        cnt_d         = cnt_q;
        periods_d     = periods_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (period == '0 || high_len == '0 || high_len >= period) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        period_d      = period;
                        high_d        = high_len;
                        npulses_d     = n_pulses;
                        pulse_count_d = WIDTH'(1);
                        periods_d     = '0;
                        cnt_d         = WIDTH'(1);
                        state_d       = HIGH;
                        sensor_d      = 1'b1;
                        busy_d        = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (stop) begin
                    state_d  = IDLE;
                    sensor_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (cnt_q == high_q) begin
                    state_d  = LOW;
                    sensor_d = 1'b0;
                    cnt_d    = WIDTH'(1);
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            LOW: begin
                if (stop) begin
                    state_d  = IDLE;
                    sensor_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (cnt_q == low_len) begin
                    periods_d = periods_inc;
                    // n_pulses of zero means run forever, counters wrap silently
                    if (npulses_q != '0 && periods_inc == npulses_q) begin
                        state_d  = IDLE;
                        sensor_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d       = HIGH;
                        sensor_d      = 1'b1;
                        cnt_d         = WIDTH'(1);
                        pulse_count_d = pulse_count_q + WIDTH'(1);
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                sensor_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sensor_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            pulse_count_q <= '0;
            period_q      <= '0;
            high_q        <= '0;
            npulses_q     <= '0;
            cnt_q         <= '0;
            periods_q     <= '0;
        end else begin
            state_q       <= state_d;
            sensor_q      <= sensor_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
            pulse_count_q <= pulse_count_d;
            period_q      <= period_d;
            high_q        <= high_d;
            npulses_q     <= npulses_d;
            cnt_q         <= cnt_d;
            periods_q     <= periods_d;
        end
    end

    assign sensor      = sensor_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_sensor_pulse_gen.sv
// tb/tb_sensor_pulse_gen.sv - directed-vector bench for sensor_pulse_gen
module tb_sensor_pulse_gen;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [WIDTH-1:0] period = '0;
    logic [WIDTH-1:0] high_len = '0;
    logic [WIDTH-1:0] n_pulses = '0;
    logic             sensor;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [WIDTH-1:0] pulse_count;

    int n_checks = 0;
    int n_pass   = 0;

    sensor_pulse_gen #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .high_len    (high_len),
        .n_pulses    (n_pulses),
        .sensor      (sensor),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .pulse_count (pulse_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic start_req(input int p, input int h, input int n);
        period   = WIDTH'(p);
        high_len = WIDTH'(h);
        n_pulses = WIDTH'(n);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at cycle 1 of a burst; returns at the negedge of the done cycle.
    task automatic run_burst(input string tag, input int p, input int h, input int n, input int poke_c);
        int total;
        logic s, b, d;
        total = n * p;
        for (int c = 1; c <= total + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (c == poke_c + 1) start = 1'b0;
            s = (c <= total) && (((c - 1) % p) < h);
            b = (c <= total);
            d = (c == total + 1);
            chk($sformatf("%s_c%0d", tag, c), {29'd0, sensor, busy, done}, {29'd0, s, b, d});
            if (c == poke_c) begin
                start = 1'b1;
                period = 8'd9;
                high_len = 8'd5;
                n_pulses = 8'd1;
            end
        end
        chk({tag, "_pc"}, 32'(pulse_count), 32'(n));
    endtask

    initial begin
        #3;
        chk("rst_sensor", 32'(sensor), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {30'd0, done, cfg_err}, 32'd0);
        chk("rst_pc", 32'(pulse_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // finite burst with an ignored start at cycle 3
        start_req(4, 1, 3);
        run_burst("fin", 4, 1, 3, 3);
        @(negedge clk);
        chk("fin_after", {30'd0, busy, done}, 32'd0);

        start_req(5, 4, 2);
        run_burst("duty", 5, 4, 2, 0);
        @(negedge clk);

        start_req(2, 1, 4);
        run_burst("minlow", 2, 1, 4, 0);
        // start in the done cycle
        start_req(2, 1, 4);
        chk("restart_sb", {30'd0, sensor, busy}, 32'd3);
        chk("restart_pc", 32'(pulse_count), 32'd1);

        // stop in HIGH
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stopH_out", {29'd0, sensor, busy, done}, 32'd0);
        chk("stopH_pc", 32'(pulse_count), 32'd1);

        // illegal configurations
        start_req(3, 3, 1);
        chk("ill33", {29'd0, cfg_err, sensor, busy}, 32'd4);
        start_req(0, 0, 1);
        chk("ill00", {29'd0, cfg_err, sensor, busy}, 32'd4);
        start_req(4, 0, 1);
        chk("ill40", {29'd0, cfg_err, sensor, busy}, 32'd4);
        chk("ill_pc", 32'(pulse_count), 32'd1);
        @(negedge clk);
        chk("ill_strobe", {29'd0, cfg_err, sensor, busy}, 32'd0);

        // start and stop together in IDLE
        stop = 1'b1;
        start_req(4, 2, 1);
        stop = 1'b0;
        chk("ss_out", {28'd0, cfg_err, sensor, busy, done}, 32'd0);
        chk("ss_pc", 32'(pulse_count), 32'd1);
        @(negedge clk);
        chk("ss_out2", {30'd0, sensor, busy}, 32'd0);

        // continuous mode: pulse_count 255 at cycle 509, 0 at cycle 511
        start_req(2, 1, 0);
        repeat (508) @(negedge clk);
        chk("cont_255", {23'd0, sensor, pulse_count}, {23'd0, 1'b1, 8'd255});
        @(negedge clk);
        chk("cont_low", {30'd0, sensor, busy}, 32'd1);
        @(negedge clk);
        chk("cont_wrap", {22'd0, sensor, busy, pulse_count}, {22'd0, 2'b11, 8'd0});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("cont_stop", {29'd0, sensor, busy, done}, 32'd0);
        chk("cont_stop_pc", 32'(pulse_count), 32'd0);

        // asynchronous reset mid-burst
        start_req(4, 2, 0);
        repeat (5) @(negedge clk);
        chk("pre_rst", {22'd0, sensor, busy, pulse_count}, {22'd0, 2'b11, 8'd2});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {22'd0, sensor, busy, pulse_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_req(3, 1, 1);
        run_burst("post_rst", 3, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
